// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control unit: decodes the ID opcode into EX/MEM/WB control
// bundles and stages them through ID/EX, EX/MEM and MEM/WB. It also handles
// load-use stalls, branch flushes in MEM and a sticky illegal-opcode flag.
module pipe_ctrl_unit #(
  parameter int OPCODE_W  = 6,
  parameter int REG_W     = 5,
  parameter int ALUOP_W   = 2,
  parameter int HAZARD_EN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                mem_alu_zero,
  output logic                ex_reg_dst,
  output logic                ex_alu_src,
  output logic [ALUOP_W-1:0]  ex_alu_op,
  output logic                mem_branch,
  output logic                mem_read,
  output logic                mem_write,
  output logic [REG_W-1:0]    mem_write_reg,
  output logic                wb_reg_write,
  output logic                wb_mem_to_reg,
  output logic [REG_W-1:0]    wb_write_reg,
  output logic                pc_src,
  output logic                pc_write,
  output logic                ifid_write,
  output logic                ifid_flush,
  output logic                illegal_op
);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

  typedef struct packed {
    logic               regDst;
    logic               aluSrc;
    logic [ALUOP_W-1:0] aluOp;
    logic               branch;
    logic               memRead;
    logic               memWrite;
    logic               regWrite;
    logic               memToReg;
  } ctrl_t;

  ctrl_t            dec;
  logic             decLegal;
  logic             usesRt;

  ctrl_t            idex;
  logic [REG_W-1:0] idexRt;
  logic [REG_W-1:0] idexRd;
  logic [REG_W-1:0] exWriteReg;

  logic             memRegWrite;
  logic             memMemToReg;

  logic             loadUse;
  logic             stall;

  // Opcode decode; usesRt marks opcodes that read rt as a source operand
  always_comb begin
    dec      = '0;
    decLegal = 1'b1;
    usesRt   = 1'b0;
    case (id_opcode)
      OP_RTYPE: begin
        dec.regDst   = 1'b1;
        dec.aluOp    = ALU_FUNCT;
        dec.regWrite = 1'b1;
        usesRt       = 1'b1;
      end
      OP_LW: begin
        dec.aluSrc   = 1'b1;
        dec.aluOp    = ALU_ADD;
        dec.memRead  = 1'b1;
        dec.regWrite = 1'b1;
        dec.memToReg = 1'b1;
      end
      OP_SW: begin
        dec.aluSrc   = 1'b1;
        dec.aluOp    = ALU_ADD;
        dec.memWrite = 1'b1;
        usesRt       = 1'b1;
      end
      OP_BEQ: begin
        dec.aluOp    = ALU_SUB;
        dec.branch   = 1'b1;
        usesRt       = 1'b1;
      end
      OP_ADDI: begin
        dec.aluSrc   = 1'b1;
        dec.aluOp    = ALU_ADD;
        dec.regWrite = 1'b1;
      end
      default: decLegal = 1'b0;
    endcase
    if (!id_valid) dec = '0;
  end

  // A load in EX whose destination is a source of the ID instruction
  assign loadUse = id_valid && idex.memRead && (idexRt != '0) &&
                   ((idexRt == id_rs) || ((idexRt == id_rt) && usesRt));
  assign stall   = (HAZARD_EN != 0) && loadUse;

  // Branch resolves in MEM; a taken branch also overrides a pending stall
  // so the target can be fetched.
  assign pc_src     = !reset && mem_branch && mem_alu_zero;
  assign ifid_flush = pc_src;
  assign pc_write   = reset || !stall || pc_src;
  assign ifid_write = pc_write;

  assign exWriteReg = idex.regDst ? idexRd : idexRt;

  assign ex_reg_dst = idex.regDst;
  assign ex_alu_src = idex.aluSrc;
  assign ex_alu_op  = idex.aluOp;

  // Control staging ID/EX -> EX/MEM -> MEM/WB with bubble insertion and the sticky illegal flag
  always_ff @(posedge clk) begin
    if (reset) begin
      idex          <= '0;
      idexRt        <= '0;
      idexRd        <= '0;
      mem_branch    <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      memRegWrite   <= 1'b0;
      memMemToReg   <= 1'b0;
      mem_write_reg <= '0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_write_reg  <= '0;
      illegal_op    <= 1'b0;
    end else begin
      if (stall || pc_src) begin
        idex   <= '0;
        idexRt <= '0;
        idexRd <= '0;
      end else begin
        idex   <= dec;
        idexRt <= id_rt;
        idexRd <= id_rd;
      end

      if (pc_src) begin
        mem_branch    <= 1'b0;
        mem_read      <= 1'b0;
        mem_write     <= 1'b0;
        memRegWrite   <= 1'b0;
        memMemToReg   <= 1'b0;
        mem_write_reg <= '0;
      end else begin
        mem_branch    <= idex.branch;
        mem_read      <= idex.memRead;
        mem_write     <= idex.memWrite;
        memRegWrite   <= idex.regWrite;
        memMemToReg   <= idex.memToReg;
        mem_write_reg <= exWriteReg;
      end

      wb_reg_write  <= memRegWrite;
      wb_mem_to_reg <= memMemToReg;
      wb_write_reg  <= mem_write_reg;

      if (id_valid && !decLegal && !stall && !pc_src) illegal_op <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: instruction-level pipeline model compared every
// cycle, plus directed literal expectations along the stimulus sequence.
module tb_pipe_ctrl_unit;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       reset, id_valid, mem_alu_zero;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;

  logic       ex_reg_dst, ex_alu_src, mem_branch, mem_read, mem_write;
  logic [1:0] ex_alu_op;
  logic [4:0] mem_write_reg, wb_write_reg;
  logic       wb_reg_write, wb_mem_to_reg, pc_src, pc_write, ifid_write, ifid_flush, illegal_op;

  logic       h0_ex_reg_dst, h0_ex_alu_src, h0_mem_branch, h0_mem_read, h0_mem_write;
  logic [1:0] h0_ex_alu_op;
  logic [4:0] h0_mem_write_reg, h0_wb_write_reg;
  logic       h0_wb_reg_write, h0_wb_mem_to_reg, h0_pc_src, h0_pc_write, h0_ifid_write;
  logic       h0_ifid_flush, h0_illegal_op;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_alu_zero(mem_alu_zero),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .mem_branch(mem_branch), .mem_read(mem_read), .mem_write(mem_write),
    .mem_write_reg(mem_write_reg), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_write_reg(wb_write_reg),
    .pc_src(pc_src), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .illegal_op(illegal_op)
  );

  pipe_ctrl_unit #(.HAZARD_EN(0)) u_h0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_alu_zero(mem_alu_zero),
    .ex_reg_dst(h0_ex_reg_dst), .ex_alu_src(h0_ex_alu_src), .ex_alu_op(h0_ex_alu_op),
    .mem_branch(h0_mem_branch), .mem_read(h0_mem_read), .mem_write(h0_mem_write),
    .mem_write_reg(h0_mem_write_reg), .wb_reg_write(h0_wb_reg_write),
    .wb_mem_to_reg(h0_wb_mem_to_reg), .wb_write_reg(h0_wb_write_reg),
    .pc_src(h0_pc_src), .pc_write(h0_pc_write), .ifid_write(h0_ifid_write),
    .ifid_flush(h0_ifid_flush), .illegal_op(h0_illegal_op)
  );

  // ---------------- model: each stage holds an instruction record ----------
  typedef struct packed {
    logic       v;
    logic [5:0] op;
    logic [4:0] rt;
    logic [4:0] rd;
  } rec_t;

  rec_t mEx = '0, mMem = '0, mWb = '0;
  logic mIll = 1'b0;

  // {RegDst, ALUSrc, ALUOp[1:0], Branch, MemRead, MemWrite, RegWrite, MemToReg}
  function automatic logic [8:0] ctl(input rec_t r);
    if (!r.v) return 9'b0;
    case (r.op)
      R:       return 9'b1_0_10_0_0_0_1_0;
      LW:      return 9'b0_1_00_0_1_0_1_1;
      SW:      return 9'b0_1_00_0_0_1_0_0;
      BEQ:     return 9'b0_0_01_1_0_0_0_0;
      ADDI:    return 9'b0_1_00_0_0_0_1_0;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [4:0] dest(input rec_t r);
    logic [8:0] c;
    c = ctl(r);
    return c[8] ? r.rd : r.rt;
  endfunction

  function automatic logic legalOp(input logic [5:0] op);
    return op == R || op == LW || op == SW || op == BEQ || op == ADDI;
  endfunction

  function automatic logic mStall();
    logic [8:0] c;
    logic readsRt;
    c = ctl(mEx);
    readsRt = (id_opcode == R) || (id_opcode == SW) || (id_opcode == BEQ);
    return id_valid && c[3] && (mEx.rt != 5'd0) &&
           ((mEx.rt == id_rs) || ((mEx.rt == id_rt) && readsRt));
  endfunction

  function automatic logic mTaken();
    logic [8:0] c;
    c = ctl(mMem);
    return !reset && c[4] && mem_alu_zero;
  endfunction

  // Advance the instruction records one stage per clock
  always @(posedge clk) begin
    if (reset) begin
      mEx <= '0; mMem <= '0; mWb <= '0; mIll <= 1'b0;
    end else begin
      mWb  <= mMem;
      mMem <= mTaken() ? rec_t'('0) : mEx;
      mEx  <= (mStall() || mTaken()) ? rec_t'('0) : rec_t'({id_valid, id_opcode, id_rt, id_rd});
      if (id_valid && !legalOp(id_opcode) && !mStall() && !mTaken()) mIll <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    logic [8:0] cEx, cMem, cWb;
    #2;
    cEx  = ctl(mEx);
    cMem = ctl(mMem);
    cWb  = ctl(mWb);
    chk("ex_reg_dst",    ex_reg_dst,    cEx[8]);
    chk("ex_alu_src",    ex_alu_src,    cEx[7]);
    chk("ex_alu_op",     ex_alu_op,     cEx[6:5]);
    chk("mem_branch",    mem_branch,    cMem[4]);
    chk("mem_read",      mem_read,      cMem[3]);
    chk("mem_write",     mem_write,     cMem[2]);
    chk("mem_write_reg", mem_write_reg, dest(mMem));
    chk("wb_reg_write",  wb_reg_write,  cWb[1]);
    chk("wb_mem_to_reg", wb_mem_to_reg, cWb[0]);
    chk("wb_write_reg",  wb_write_reg,  dest(mWb));
    chk("pc_src",        pc_src,        mTaken());
    chk("ifid_flush",    ifid_flush,    mTaken());
    chk("pc_write",      pc_write,      reset || !mStall() || mTaken());
    chk("ifid_write",    ifid_write,    reset || !mStall() || mTaken());
    chk("illegal_op",    illegal_op,    mIll);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic v, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic z);
    @(negedge clk);
    reset = r; id_valid = v; id_opcode = op;
    id_rs = rs; id_rt = rt; id_rd = rd; mem_alu_zero = z;
    #3;
  endtask

  task automatic id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                    input logic [4:0] rd, input logic z);
    drive(1'b0, 1'b1, op, rs, rt, rd, z);
  endtask

  task automatic bub(input logic z);
    drive(1'b0, 1'b0, 6'd0, 5'd0, 5'd0, 5'd0, z);
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b1; id_opcode = BAD;
    id_rs = 5'd31; id_rt = 5'd17; id_rd = 5'd9; mem_alu_zero = 1'b1;

    // reset with garbage on the inputs
    drive(1'b1, 1'b1, BAD, 5'd31, 5'd17, 5'd9, 1'b1);
    drive(1'b1, 1'b1, LW, 5'd5, 5'd5, 5'd5, 1'b1);
    chk("rst_ex_alu_op", ex_alu_op, 2'd0);
    chk("rst_wb_write_reg", wb_write_reg, 5'd0);
    chk("rst_pc_write", pc_write, 1'b1);
    chk("rst_illegal", illegal_op, 1'b0);

    // pass-through R, lw, sw, beq, addi
    id(R, 5'd1, 5'd2, 5'd3, 1'b0);
    id(LW, 5'd1, 5'd4, 5'd9, 1'b0);
    chk("pt_ex_reg_dst_R", ex_reg_dst, 1'b1);
    chk("pt_ex_alu_op_R", ex_alu_op, 2'b10);
    id(SW, 5'd6, 5'd0, 5'd0, 1'b0);
    chk("pt_mem_wreg_R", mem_write_reg, 5'd3);
    chk("pt_ex_alu_src_lw", ex_alu_src, 1'b1);
    id(BEQ, 5'd7, 5'd8, 5'd0, 1'b0);
    chk("pt_wb_wreg_R", wb_write_reg, 5'd3);
    chk("pt_mem_read_lw", mem_read, 1'b1);
    chk("pt_mem_wreg_lw", mem_write_reg, 5'd4);
    id(ADDI, 5'd1, 5'd10, 5'd0, 1'b0);
    chk("pt_wb_wreg_lw", wb_write_reg, 5'd4);
    chk("pt_wb_m2r_lw", wb_mem_to_reg, 1'b1);
    chk("pt_ex_alu_op_beq", ex_alu_op, 2'b01);
    bub(1'b0);
    chk("pt_wb_wreg_sw", wb_write_reg, 5'd0);
    chk("pt_wb_rw_sw", wb_reg_write, 1'b0);
    chk("pt_mem_branch_beq", mem_branch, 1'b1);
    bub(1'b0);
    bub(1'b0);
    chk("pt_wb_wreg_addi", wb_write_reg, 5'd10);
    bub(1'b0);

    // load-use on rs: one stall cycle, then the add proceeds
    id(LW, 5'd1, 5'd5, 5'd0, 1'b0);
    id(R, 5'd5, 5'd6, 5'd7, 1'b0);
    chk("lu_pc_write", pc_write, 1'b0);
    chk("lu_ifid_write", ifid_write, 1'b0);
    chk("lu_nohaz_pc_write", h0_pc_write, 1'b1);
    id(R, 5'd5, 5'd6, 5'd7, 1'b0);
    chk("lu_bubble_alu_op", ex_alu_op, 2'd0);
    chk("lu_bubble_reg_dst", ex_reg_dst, 1'b0);
    chk("lu_released", pc_write, 1'b1);
    bub(1'b0);
    chk("lu_add_reg_dst", ex_reg_dst, 1'b1);

    // load rt=0: no stall
    id(LW, 5'd1, 5'd0, 5'd0, 1'b0);
    id(R, 5'd0, 5'd6, 5'd7, 1'b0);
    chk("lu_rt0_pc_write", pc_write, 1'b1);
    bub(1'b0);

    // rt match: addi does not read rt, sw does
    id(LW, 5'd1, 5'd5, 5'd0, 1'b0);
    id(ADDI, 5'd2, 5'd5, 5'd0, 1'b0);
    chk("lu_addi_rt_nostall", pc_write, 1'b1);
    id(LW, 5'd1, 5'd5, 5'd0, 1'b0);
    id(SW, 5'd2, 5'd5, 5'd0, 1'b0);
    chk("lu_sw_rt_stall", pc_write, 1'b0);
    id(SW, 5'd2, 5'd5, 5'd0, 1'b0);
    bub(1'b0);
    bub(1'b0);

    // taken branch flushes the two younger instructions
    id(BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    id(ADDI, 5'd3, 5'd11, 5'd0, 1'b0);
    id(R, 5'd3, 5'd4, 5'd12, 1'b1);
    chk("br_pc_src", pc_src, 1'b1);
    chk("br_flush", ifid_flush, 1'b1);
    bub(1'b1);
    chk("br_pc_src_drop", pc_src, 1'b0);
    chk("br_ex_bubble", ex_reg_dst, 1'b0);
    chk("br_mem_bubble_wreg", mem_write_reg, 5'd0);
    bub(1'b0);
    chk("br_wb_young1", wb_reg_write, 1'b0);
    bub(1'b0);
    chk("br_wb_young2", wb_reg_write, 1'b0);

    // stall and flush together: flush wins
    id(BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    id(LW, 5'd1, 5'd5, 5'd0, 1'b0);
    id(R, 5'd5, 5'd6, 5'd7, 1'b1);
    chk("sf_pc_write", pc_write, 1'b1);
    chk("sf_ifid_write", ifid_write, 1'b1);
    chk("sf_flush", ifid_flush, 1'b1);
    id(ADDI, 5'd5, 5'd1, 5'd0, 1'b0);
    chk("sf_ex_bubble", ex_alu_src, 1'b0);
    chk("sf_mem_read_killed", mem_read, 1'b0);
    chk("sf_no_extra_stall", pc_write, 1'b1);
    bub(1'b0);
    bub(1'b0);

    // illegal opcode squashed by a flush does not set the flag
    id(BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
    bub(1'b0);
    id(BAD, 5'd0, 5'd0, 5'd0, 1'b1);
    bub(1'b0);
    chk("ill_flushed", illegal_op, 1'b0);

    // sticky illegal_op
    id(BAD, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("ill_before", illegal_op, 1'b0);
    id(R, 5'd1, 5'd2, 5'd3, 1'b0);
    chk("ill_set", illegal_op, 1'b1);
    id(ADDI, 5'd1, 5'd2, 5'd0, 1'b0);
    bub(1'b0);
    chk("ill_sticky", illegal_op, 1'b1);

    // reset during a stall
    id(LW, 5'd1, 5'd5, 5'd0, 1'b0);
    drive(1'b1, 1'b1, R, 5'd5, 5'd6, 5'd7, 1'b0);
    chk("rs_pc_write", pc_write, 1'b1);
    bub(1'b0);
    chk("rs_illegal_clr", illegal_op, 1'b0);
    chk("rs_mem_read", mem_read, 1'b0);
    bub(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
